// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// ALU operands are registered on accept and the ALU result is captured one cycle later.
module alu_arbiter #(
   parameter int         NREQ   = 2,
   parameter int         W      = 32,
   parameter logic [3:0] MAX_OP = 4'hC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   resp_valid,
   input  logic [NREQ-1:0]   resp_ready,
   output logic [W-1:0]      resp_out,
   output logic [2:0]        resp_flags,
   output logic              resp_err,
   output logic [3:0]        alu_op,
   output logic [W-1:0]      alu_in0,
   output logic [W-1:0]      alu_in1,
   input  logic [W-1:0]      alu_out,
   input  logic              alu_ovf,
   input  logic              alu_zero,
   input  logic              alu_cout,
   output logic              busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   grant;
   logic [PW-1:0]   pick;
   logic            found;
   logic [NREQ-1:0] rot;
   logic [PW:0]     offset;
   logic [PW:0]     sum;
   logic [3:0]      sel_op;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;

   // Rotate the valids so bit 0 is the requester at rr_ptr, take the lowest set bit,
   // then map the offset back to an absolute requester index.
   always_comb begin
      rot    = NREQ'({req_valid, req_valid} >> rr_ptr);
      found  = 1'b0;
      offset = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found  = 1'b1;
            offset = (PW+1)'(k);
         end
      end
      sum = {1'b0, rr_ptr} + offset;
      if (sum >= NREQ_W) begin
         sum = sum - NREQ_W;
      end
      pick = sum[PW-1:0];
   end

   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (PW'(j) == pick) begin
            sel_op = req_op[j*4 +: 4];
            sel_a  = req_a[j*W +: W];
            sel_b  = req_b[j*W +: W];
         end
      end
   end

   // Gated with rst_n so that no handshake is offered while reset is held.
   assign req_ready = (rst_n && state == IDLE && found) ? (NREQ'(1) << pick) : '0;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant      <= '0;
         alu_op     <= '0;
         alu_in0    <= '0;
         alu_in1    <= '0;
         resp_valid <= '0;
         resp_out   <= '0;
         resp_flags <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant  <= pick;
                  rr_ptr <= (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
                  if (sel_op > MAX_OP) begin
                     // Illegal opcode: never issued, the ALU keeps its previous operands.
                     resp_out   <= '0;
                     resp_flags <= '0;
                     resp_err   <= 1'b1;
                     resp_valid <= NREQ'(1) << pick;
                     state      <= RESP;
                  end else begin
                     alu_op  <= sel_op;
                     alu_in0 <= sel_a;
                     alu_in1 <= sel_b;
                     state   <= EXEC;
                  end
               end
            end
            EXEC: begin
               resp_out   <= alu_out;
               resp_flags <= {alu_ovf, alu_zero, alu_cout};
               resp_err   <= 1'b0;
               resp_valid <= NREQ'(1) << grant;
               state      <= RESP;
            end
            RESP: begin
               if (|(resp_ready & resp_valid)) begin
                  resp_valid <= '0;
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU stands in for the shared ALU,
// and a transaction-level model predicts grants, latency and responses.
module tb_alu_arbiter;

   localparam int NREQ = 2;
   localparam int W    = 32;
   localparam logic [3:0] MAX_OP = 4'hC;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [4*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_a;
   logic [W*NREQ-1:0] req_b;
   logic [NREQ-1:0]   resp_valid;
   logic [NREQ-1:0]   resp_ready;
   logic [W-1:0]      resp_out;
   logic [2:0]        resp_flags;
   logic              resp_err;
   logic [3:0]        alu_op;
   logic [W-1:0]      alu_in0;
   logic [W-1:0]      alu_in1;
   logic [W-1:0]      alu_out;
   logic              alu_ovf;
   logic              alu_zero;
   logic              alu_cout;
   logic              busy;

   int checks = 0;
   int errors = 0;

   int          exp_ptr;
   logic [3:0]  exp_alu_op;
   logic [31:0] exp_in0;
   logic [31:0] exp_in1;
   logic [31:0] exp_out;
   logic [2:0]  exp_flags;
   logic        exp_err;

   alu_arbiter #(.NREQ(NREQ), .W(W), .MAX_OP(MAX_OP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_out   (resp_out),
      .resp_flags (resp_flags),
      .resp_err   (resp_err),
      .alu_op     (alu_op),
      .alu_in0    (alu_in0),
      .alu_in1    (alu_in1),
      .alu_out    (alu_out),
      .alu_ovf    (alu_ovf),
      .alu_zero   (alu_zero),
      .alu_cout   (alu_cout),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {overflow, zero, carryout, result}.
   function automatic logic [34:0] aluModel(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [32:0] wide;
      logic [31:0] s;
      logic        ovf;
      logic        cout;
      ovf  = 1'b0;
      cout = 1'b0;
      wide = '0;
      case (op)
         4'h0: begin s = a + b; ovf = (a[31] == b[31]) && (s[31] != a[31]); end
         4'h1: begin wide = {1'b0, a} + {1'b0, b}; s = wide[31:0]; cout = wide[32]; end
         4'h2: begin s = a - b; ovf = (a[31] != b[31]) && (s[31] != a[31]); end
         4'h3: begin s = a - b; cout = (a < b); end
         4'h4: s = a & b;
         4'h5: s = a | b;
         4'h6: s = a ^ b;
         4'h7: s = ~(a | b);
         4'h8: s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'h9: s = (a < b) ? 32'd1 : 32'd0;
         4'hA: s = a << b[4:0];
         4'hB: s = a >> b[4:0];
         4'hC: s = $unsigned($signed(a) >>> b[4:0]);
         default: s = '0;
      endcase
      return {ovf, (s == 32'd0), cout, s};
   endfunction

   logic [34:0] alu_res;
   always_comb alu_res = aluModel(alu_op, alu_in0, alu_in1);
   assign {alu_ovf, alu_zero, alu_cout, alu_out} = alu_res;

   function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] otherBits(input int g);
      logic [NREQ-1:0] r;
      r = NREQ'($urandom);
      r[g] = 1'b0;
      return r;
   endfunction

   task automatic scrambleRequests();
      req_valid = NREQ'($urandom);
      req_op    = (4*NREQ)'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
   endtask

   // Called just after a falling edge; returns just after a falling edge.
   task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [4*NREQ-1:0] ops,
                                input logic [W*NREQ-1:0] as, input logic [W*NREQ-1:0] bs,
                                input int stall);
      int          g;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [NREQ-1:0] gmask;
      req_valid  = valid;
      req_op     = ops;
      req_a      = as;
      req_b      = bs;
      resp_ready = '0;
      #1;
      g = pickGrant(valid, exp_ptr);
      if (g < 0) begin
         checkOutput("idle_ready", req_ready, 0);
         @(posedge clk); @(negedge clk); #1;
         checkOutput("idle_resp_valid", resp_valid, 0);
         checkOutput("idle_busy", busy, 0);
         return;
      end
      gmask = NREQ'(1) << g;
      op = ops[g*4 +: 4];
      a  = as[g*W +: W];
      b  = bs[g*W +: W];
      checkOutput("req_ready", req_ready, gmask);
      checkOutput("busy_idle", busy, 0);
      exp_ptr = (g + 1) % NREQ;

      @(posedge clk); @(negedge clk);
      scrambleRequests();
      resp_ready = otherBits(g);
      if (op <= MAX_OP) begin
         #1;
         checkOutput("exec_busy", busy, 1);
         checkOutput("exec_ready", req_ready, 0);
         checkOutput("exec_resp_valid", resp_valid, 0);
         checkOutput("exec_alu_op", alu_op, op);
         checkOutput("exec_alu_in0", alu_in0, a);
         checkOutput("exec_alu_in1", alu_in1, b);
         exp_alu_op = op;
         exp_in0    = a;
         exp_in1    = b;
         {exp_flags, exp_out} = aluModel(op, a, b);
         exp_err = 1'b0;
         @(posedge clk); @(negedge clk);
         scrambleRequests();
         resp_ready = otherBits(g);
      end else begin
         exp_out   = '0;
         exp_flags = '0;
         exp_err   = 1'b1;
      end
      #1;
      checkOutput("resp_valid", resp_valid, gmask);
      checkOutput("resp_out", resp_out, exp_out);
      checkOutput("resp_flags", resp_flags, exp_flags);
      checkOutput("resp_err", resp_err, exp_err);
      checkOutput("resp_ready_blocked", req_ready, 0);
      checkOutput("alu_hold", {alu_op, alu_in0, alu_in1}, {exp_alu_op, exp_in0, exp_in1});

      for (int s = 0; s < stall; s++) begin
         @(posedge clk); @(negedge clk);
         scrambleRequests();
         resp_ready = otherBits(g);
         #1;
         checkOutput("stall_resp_valid", resp_valid, gmask);
         checkOutput("stall_resp_out", {resp_err, resp_flags, resp_out},
                     {exp_err, exp_flags, exp_out});
         checkOutput("stall_ready", req_ready, 0);
      end

      resp_ready = NREQ'($urandom) | gmask;
      req_valid  = '0;
      @(posedge clk); @(negedge clk);
      resp_ready = '0;
      #1;
      checkOutput("post_resp_valid", resp_valid, 0);
      checkOutput("post_busy", busy, 0);
      checkOutput("post_hold", {resp_err, resp_flags, resp_out}, {exp_err, exp_flags, exp_out});
   endtask

   task automatic resetDuringExec();
      req_valid = 2'b01;
      req_op    = 8'h00;
      req_a     = {32'd9, 32'd21};
      req_b     = {32'd4, 32'd13};
      @(posedge clk); @(negedge clk); #1;
      checkOutput("pre_reset_busy", busy, 1);
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_alu", {alu_op, alu_in0, alu_in1}, 0);
      checkOutput("rst_resp", {resp_err, resp_flags, resp_out}, 0);
      exp_ptr    = 0;
      exp_alu_op = '0;
      exp_in0    = '0;
      exp_in1    = '0;
      exp_out    = '0;
      exp_flags  = '0;
      exp_err    = 1'b0;
      #1;
      rst_n = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); @(negedge clk); #1;
         checkOutput("after_rst_no_resp", resp_valid, 0);
         checkOutput("after_rst_busy", busy, 0);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      req_op     = '0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = '0;
      exp_ptr    = 0;
      exp_alu_op = '0;
      exp_in0    = '0;
      exp_in1    = '0;
      exp_out    = '0;
      exp_flags  = '0;
      exp_err    = 1'b0;
      #3;
      checkOutput("reset_ready", req_ready, 0);
      checkOutput("reset_resp", {resp_valid, resp_err, resp_flags, resp_out}, 0);
      checkOutput("reset_alu", {alu_op, alu_in0, alu_in1}, 0);
      checkOutput("reset_busy", busy, 0);
      @(negedge clk); #1;
      req_valid = '0;
      rst_n = 1'b1;

      $display("[TB] contention sub 3-3");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b11, {4'h2, 4'h2}, {32'd3, 32'd3}, {32'd3, 32'd3}, 0);
      end

      $display("[TB] single add");
      applyStimulus(2'b01, 8'h00, {32'd0, 32'd5}, {32'd0, 32'd7}, 0);
      checkOutput("add_const", {resp_err, resp_flags, resp_out}, {1'b0, 3'b000, 32'd12});

      $display("[TB] overflow passthrough");
      applyStimulus(2'b01, 8'h00, {32'd0, 32'h7FFFFFFF}, {32'd0, 32'd1}, 0);
      checkOutput("ovf_const", {resp_flags, resp_out}, {3'b100, 32'h80000000});
      applyStimulus(2'b10, {4'h3, 4'h0}, {32'd0, 32'd0}, {32'd1, 32'd0}, 0);
      checkOutput("subu_const", {resp_flags, resp_out}, {3'b001, 32'hFFFFFFFF});

      $display("[TB] illegal op");
      applyStimulus(2'b10, {4'hE, 4'h0}, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      checkOutput("illegal_alu_op", alu_op, 4'h3);

      $display("[TB] backpressure");
      applyStimulus(2'b11, {4'h1, 4'h6}, {$urandom, $urandom}, {$urandom, $urandom}, 10);
      applyStimulus(2'b11, {4'h4, 4'h5}, {$urandom, $urandom}, {$urandom, $urandom}, 0);

      $display("[TB] reset during EXEC");
      resetDuringExec();
      applyStimulus(2'b11, {4'h0, 4'h0}, {32'd1, 32'd2}, {32'd3, 32'd4}, 0);
      checkOutput("after_rst_grant0", resp_out, 32'd6);

      $display("[TB] random traffic");
      for (int i = 0; i < 40; i++) begin
         applyStimulus(NREQ'($urandom_range(0, 3)),
                       {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
                       {$urandom, $urandom}, {$urandom, $urandom},
                       $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
